// File: rtl/nebula_pqc_arbiter.sv
// ---------------------------------------------------------------------------
// nebula_pqc_arbiter
//
// Shares a single nebula_pqc_core among NREQ requesters. A requester is picked
// round-robin and its 256-bit seed is latched. The core is then cleared,
// started and watched until it reports done or the job times out. The result
// is returned to the requester as a one-cycle ack, with err marking a timeout.
//
// Parameters
//   NREQ     number of requesters
//   TIMEOUT  maximum number of WAIT cycles before a job is aborted with err=1
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high reset
//   req         per-requester job request, held until the matching ack
//   seed_in     requester i seed in bits [256*i+255:256*i]
//   ack         one-cycle job-complete pulse to the granted requester
//   err         valid with ack: 1 = timed out, 0 = core completed
//   grant_id    index of the current or last granted requester
//   busy        high whenever the arbiter is not idle
//   core_rst_n  active-low core reset (flop output)
//   core_start  core start (flop output)
//   core_seed   seed presented to the core (flop output)
//   core_done   sticky done from the core, cleared only by core_rst_n
// ---------------------------------------------------------------------------
module nebula_pqc_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*256-1:0]   seed_in,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  core_rst_n,
  output logic                  core_start,
  output logic [255:0]          core_seed,
  input  logic                  core_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic            err_next;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  logic            out_of_reset;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;
  logic [255:0]    pick_seed;
  logic [NREQ-1:0] ack_next;

  // Round-robin search starting at rr_ptr. Walking the offsets from highest
  // to lowest lets the smallest offset with a pending request win last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Seed of the requester about to be granted.
  always_comb begin
    pick_seed = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) begin
        pick_seed = seed_in[256*i +: 256];
      end
    end
  end

  // One-hot ack pattern for the current grant.
  always_comb begin
    ack_next = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_next[i] = (grant_id == IDW'(i));
    end
  end

  // Next-state logic. A finishing core beats the timeout in the same cycle.
  // The first cycle out of reset never grants, so the core sees core_rst_n
  // high for one cycle before its first clear.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE:  if (out_of_reset && pick_valid) state_next = CLEAR;
      CLEAR: state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (core_done) begin
          state_next = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered state and outputs. Core controls and ack/err are computed from
  // the next state so that they are flop outputs aligned with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      core_seed    <= '0;
      ack          <= '0;
      err          <= 1'b0;
      core_start   <= 1'b0;
      core_rst_n   <= 1'b0;
      cnt          <= '0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      state        <= state_next;
      core_start   <= (state_next == START) || (state_next == WAIT);
      core_rst_n   <= (state_next != CLEAR);
      ack          <= '0;
      err          <= 1'b0;
      if (state_next == DONE) begin
        ack <= ack_next;
        err <= err_next;
      end
      case (state)
        IDLE: begin
          if (state_next == CLEAR) begin
            grant_id  <= pick_id;
            core_seed <= pick_seed;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          // Stops at TIMEOUT-1 so the counter can never wrap.
          if (!core_done && (cnt != CW'(TIMEOUT - 1))) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (int'(grant_id) == NREQ - 1) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= grant_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_nebula_pqc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nebula_pqc_arbiter
//
// Self-checking bench for nebula_pqc_arbiter with a small core model whose
// done latency is programmable (core_lat = number of start cycles before done,
// 0 = never finishes). Directed sequences, a job vector table and a random
// phase checked against a job-timeline reference model.
// ---------------------------------------------------------------------------
module tb_nebula_pqc_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*256-1:0] seed_in = '0;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic [1:0]          grant_id;
  logic                busy;
  logic                core_rst_n;
  logic                core_start;
  logic [255:0]        core_seed;
  logic                core_done = 1'b0;

  int core_lat = 1;
  int core_cycles = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [NREQ-1:0] req;
    int              lat;
    logic [1:0]      gid;
    logic            err;
    int              latency;
  } vec_t;

  vec_t vecs[6];

  // Reference model state: one job timeline (age 1 = clear, 2 = start,
  // 3..2+W = wait, 3+W = done).
  logic            m_hold = 1'b1;
  logic            m_rst = 1'b1;
  logic            m_active = 1'b0;
  int              m_age = 0;
  int              m_w = 0;
  logic            m_err = 1'b0;
  int              m_gid = 0;
  int              m_rr = 0;
  logic [255:0]    m_seed = '0;
  logic [NREQ-1:0] e_ack = '0;

  always #5 clk = ~clk;

  nebula_pqc_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .seed_in    (seed_in),
    .ack        (ack),
    .err        (err),
    .grant_id   (grant_id),
    .busy       (busy),
    .core_rst_n (core_rst_n),
    .core_start (core_start),
    .core_seed  (core_seed),
    .core_done  (core_done)
  );

  // Core model: counts start cycles and raises a sticky done after core_lat.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_cycles <= 0;
      core_done   <= 1'b0;
    end else if (core_start && !core_done) begin
      core_cycles <= core_cycles + 1;
      if (core_lat != 0 && core_cycles + 1 == core_lat) core_done <= 1'b1;
    end
  end

  function automatic logic [255:0] seed_of(input int i);
    return {8{32'(32'h5EED0000 + i)}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_quiet();
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    applyStimulus(1'b0, '0);
  endtask

  task automatic wait_ack(input logic [NREQ-1:0] r, output int n);
    n = 0;
    do begin
      applyStimulus(1'b0, r);
      n++;
    end while (ack == '0 && n < 40);
  endtask

  // Model step for the coming edge, using the inputs currently applied.
  task automatic model_update();
    logic found;
    int   c;
    if (reset) begin
      m_hold = 1'b1; m_rst = 1'b1; m_active = 1'b0; m_age = 0;
      m_rr = 0; m_gid = 0; m_seed = '0;
    end else begin
      m_rst = 1'b0;
      if (m_hold) begin
        m_hold = 1'b0;
      end else if (m_active) begin
        if (m_age == 3 + m_w) begin
          m_active = 1'b0;
          m_rr = (m_gid + 1) % NREQ;
        end else begin
          m_age++;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (!found && req[c]) begin
            found = 1'b1;
            m_active = 1'b1; m_age = 1; m_gid = c;
            m_seed = seed_in[256*c +: 256];
            if (core_lat >= 1 && core_lat <= TIMEOUT) begin
              m_w = core_lat; m_err = 1'b0;
            end else begin
              m_w = TIMEOUT; m_err = 1'b1;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    int nack;
    int last_cyc;
    logic [NREQ-1:0] r;
    logic [255:0] s;
    logic e_done, e_start, e_rstn;

    for (int i = 0; i < NREQ; i++) seed_in[256*i +: 256] = seed_of(i);

    vecs[0] = '{4'b0100,  1, 2'd2, 1'b0,  4};
    vecs[1] = '{4'b1010,  5, 2'd1, 1'b0,  8};
    vecs[2] = '{4'b1000, 16, 2'd3, 1'b0, 19};
    vecs[3] = '{4'b0001, 17, 2'd0, 1'b1, 19};
    vecs[4] = '{4'b0110,  0, 2'd1, 1'b1, 19};
    vecs[5] = '{4'b1111,  2, 2'd0, 1'b0,  5};

    // Reset held with every requester asking.
    core_lat = 1;
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("rst_ack", ack, '0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_core_start", core_start, 1'b0);
    checkOutput("rst_core_rst_n", core_rst_n, 1'b0);
    checkOutput("rst_grant_id", grant_id, 2'd0);
    checkOutput("rst_core_seed", core_seed, '0);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("post_rst_core_rst_n", core_rst_n, 1'b1);
    checkOutput("post_rst_busy", busy, 1'b0);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("first_grant_id", grant_id, 2'd0);
    checkOutput("first_grant_clear", core_rst_n, 1'b0);

    // All four requesting continuously: rotation 0,1,2,3 with 5-cycle spacing.
    nack = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      applyStimulus(1'b0, (nack >= 8) ? 4'b0000 : 4'b1111);
      if (ack != '0) begin
        checkOutput($sformatf("rr_ack%0d", nack), ack, 4'b0001 << (nack % 4));
        checkOutput($sformatf("rr_err%0d", nack), err, 1'b0);
        if (nack > 0) checkOutput($sformatf("rr_spacing%0d", nack), cyc - last_cyc, 5);
        last_cyc = cyc;
        nack++;
      end
    end
    checkOutput("rr_job_count", nack, 8);

    // Single-job vector table, each from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      reset_quiet();
      core_lat = vecs[v].lat;
      wait_ack(vecs[v].req, n);
      checkOutput($sformatf("vec%0d_latency", v), n, vecs[v].latency);
      checkOutput($sformatf("vec%0d_ack", v), ack, 4'b0001 << vecs[v].gid);
      checkOutput($sformatf("vec%0d_err", v), err, vecs[v].err);
      checkOutput($sformatf("vec%0d_grant_id", v), grant_id, vecs[v].gid);
      checkOutput($sformatf("vec%0d_core_start", v), core_start, 1'b0);
      checkOutput($sformatf("vec%0d_core_seed", v), core_seed, seed_of(int'(vecs[v].gid)));
      applyStimulus(1'b0, '0);
      checkOutput($sformatf("vec%0d_ack_clear", v), ack, '0);
      checkOutput($sformatf("vec%0d_idle", v), busy, 1'b0);
    end

    // A requester re-requesting right after its ack goes behind the others.
    reset_quiet();
    core_lat = 1;
    wait_ack(4'b0001, n);
    checkOutput("fair_ack0", ack, 4'b0001);
    wait_ack(4'b1011, n);
    checkOutput("fair_ack1", ack, 4'b0010);
    wait_ack(4'b1001, n);
    checkOutput("fair_ack2", ack, 4'b1000);
    wait_ack(4'b0001, n);
    checkOutput("fair_ack3", ack, 4'b0001);

    // Detailed timing of one job for requester 2.
    reset_quiet();
    core_lat = 1;
    s = 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
    seed_in[767:512] = s;
    applyStimulus(1'b0, 4'b0100);
    checkOutput("t1_core_rst_n", core_rst_n, 1'b0);
    checkOutput("t1_busy", busy, 1'b1);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("t2_core_start", core_start, 1'b1);
    checkOutput("t2_core_seed", core_seed, s);
    checkOutput("t2_core_rst_n", core_rst_n, 1'b1);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("t3_ack", ack, '0);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("t4_ack", ack, 4'b0100);
    checkOutput("t4_err", err, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("t5_ack", ack, '0);
    seed_in[767:512] = seed_of(2);

    // Reset during the third WAIT cycle of a job for requester 1.
    reset_quiet();
    core_lat = 0;
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 4'b0010);
    checkOutput("abort_wait_start", core_start, 1'b1);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ack", ack, '0);
    checkOutput("abort_core_rst_n", core_rst_n, 1'b0);
    core_lat = 1;
    applyStimulus(1'b0, 4'b0010);
    checkOutput("abort_quiet_ack", ack, '0);
    wait_ack(4'b0010, n);
    checkOutput("abort_regrant_id", grant_id, 2'd1);
    checkOutput("abort_regrant_ack", ack, 4'b0010);
    checkOutput("abort_regrant_err", err, 1'b0);

    // Random phase against the job-timeline model.
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (e_ack[k]) r[k] = 1'($urandom_range(0, 1));
        else if (!r[k]) r[k] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 29) == 0) r[k] = 1'b0;
      end
      if (!m_active)
        core_lat = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(0, 20));
      for (int w = 0; w < NREQ * 8; w++) seed_in[32*w +: 32] = $urandom();
      reset = (i < 2) ? 1'b1 : ($urandom_range(0, 199) == 0);
      req = r;
      model_update();
      @(posedge clk);
      #1;
      e_done  = m_active && (m_age == 3 + m_w);
      e_start = m_active && (m_age >= 2) && (m_age <= 2 + m_w);
      e_rstn  = !m_rst && !(m_active && m_age == 1);
      e_ack   = e_done ? (4'b0001 << m_gid) : 4'b0000;
      checkOutput($sformatf("rnd%0d_ack", i), ack, e_ack);
      checkOutput($sformatf("rnd%0d_err", i), err, e_done && m_err);
      checkOutput($sformatf("rnd%0d_busy", i), busy, m_active);
      checkOutput($sformatf("rnd%0d_core_start", i), core_start, e_start);
      checkOutput($sformatf("rnd%0d_core_rst_n", i), core_rst_n, e_rstn);
      checkOutput($sformatf("rnd%0d_grant_id", i), grant_id, m_gid);
      checkOutput($sformatf("rnd%0d_core_seed", i), core_seed, m_seed);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nebula_pqc_arbiter.md
NEBULA_PQC_ARBITER -- requirements
Module: nebula_pqc_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one nebula_pqc_core.
REQ-002 Parameter TIMEOUT, default 16, maximum WAIT cycles before a job is aborted with an error.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester job request; held high until the matching ack.
REQ-006 seed_in  input  NREQ*256  requester i seed in bits [256*i+255:256*i].
REQ-007 ack  output  NREQ  one-cycle job-complete pulse to the granted requester.
REQ-008 err  output  1  valid with ack; 1 = job timed out, 0 = core completed.
REQ-009 grant_id  output  clog2(NREQ)  index of the current or last granted requester.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 core_rst_n  output  1  active-low reset to the core, driven directly from a flip-flop.
REQ-012 core_start  output  1  start to the core, registered.
REQ-013 core_seed  output  256  seed to the core, registered.
REQ-014 core_done  input  1  done from the core; stays high until the core is reset.

Function
REQ-015 FSM states: IDLE, CLEAR, START, WAIT, DONE; each state lasts one cycle except IDLE and WAIT.
REQ-016 IDLE with any req bit high: grant the first set bit found by round-robin search from rr_ptr upward, with wrap at NREQ-1 -> 0.
- In the same edge: latch grant_id, latch that requester's seed into core_seed, go to CLEAR.
REQ-017 CLEAR: core_rst_n=0 for exactly one cycle to clear the core's sticky done; go to START.
REQ-018 START: core_start=1; timeout counter cleared to 0; go to WAIT.
REQ-019 WAIT: core_start held 1; counter increments each cycle.
- core_done=1: go to DONE with err_next=0.
- Else, counter==TIMEOUT-1: go to DONE with err_next=1.
- core_done wins if both occur in the same cycle.
REQ-020 DONE: ack[grant_id]=1 and err valid for this cycle only; core_start=0; rr_ptr=(grant_id+1) mod NREQ; go to IDLE.
REQ-021 Outside DONE, ack=0 and err=0.
REQ-022 core_start=0 in IDLE, CLEAR and DONE; core_rst_n=1 in all states except CLEAR.
REQ-023 core_seed and grant_id hold their values from grant until the next grant.
REQ-024 Latency with a core that completes immediately: req sampled in IDLE at cycle T -> ack at cycle T+4; minimum job spacing 5 cycles.
REQ-025 Dropping req mid-job does not abort the job; ack is still pulsed.
REQ-026 req deasserted while in IDLE is never granted.
REQ-027 A requester re-requesting right after its ack is granted only after all other pending requesters.
REQ-028 Timeout counter width is clog2(TIMEOUT+1); the counter never wraps.
REQ-029 WAIT lasts at most TIMEOUT cycles.

Reset
REQ-030 While reset=1 the block holds: state IDLE, rr_ptr=0, grant_id=0, core_seed=0, ack=0, err=0, busy=0, core_start=0, core_rst_n=0 (core held in reset).
REQ-031 The first cycle after reset deasserts, core_rst_n=1.
REQ-032 Reset asserted in any state, including mid-WAIT, returns to IDLE on the next edge with no ack issued; the interrupted job is lost.

Verification
REQ-033 reset high 2 cycles with req=4'b1111 -> ack=0, busy=0, core_start=0, core_rst_n=0; after release core_rst_n=1, first grant_id=0.
REQ-034 req=4'b0100 at T, seed_in[767:512]=S, real core model -> core_rst_n=0 at T+1, core_seed=S and core_start=1 at T+2, ack=4'b0100 with err=0 at T+4.
REQ-035 req=4'b1111 held continuously, acks dropped only after 8 jobs -> ack order 0,1,2,3,0,1,2,3, spaced 5 cycles apart.
REQ-036 core_done tied 0, TIMEOUT=16 -> WAIT lasts 16 cycles; ack with err=1 on the 17th cycle after START; core_start=0 in that cycle.
REQ-037 core_done rises exactly on WAIT cycle 16 (counter==15) -> ack with err=0.
REQ-038 reset pulsed during cycle 3 of WAIT on a job for requester 1 -> IDLE next cycle, no ack, pending req=4'b0010 re-granted afterwards with grant_id=1.
